// File: rtl/mdu.sv
// mdu -- RV32M multiply/divide unit
//
// Iterative multiply/divide unit. Accepts one request at a time and produces
// one result per request.
//   clk, rst_n         : single clock; synchronous active-low reset
//   flush              : abort any in-flight or completed-but-unconsumed operation
//   req_valid/req_ready: request handshake (req_ready only in IDLE)
//   req_op             : funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   req_operand1/2     : rs1/rs2 values
//   req_rd             : destination tag, returned unchanged on resp_rd
//   resp_valid/ready   : response handshake
//   resp_result        : 32-bit RV32M result
//   resp_rd            : tag of the completed request
//
// Multiply is a 32-step radix-2 shift-add over magnitudes. Divide is a
// 32-step restoring division over magnitudes. Signs are reapplied when the
// result is registered on entry to DONE. Divide-by-zero and signed overflow
// bypass iteration and complete on the edge after acceptance.

package _riscv_defines;
  localparam int DATA_WIDTH = 32;
endpackage

module mdu
  import _riscv_defines::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_operand1,
  input  logic [DATA_WIDTH-1:0] req_operand2,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic [4:0]            resp_rd
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                  state;
  logic [4:0]              cnt;
  logic [1:0]              op_q;
  logic [4:0]              rd_q;
  logic [DATA_WIDTH-1:0]   opnd_q;
  logic [2*DATA_WIDTH-1:0] acc_q;
  logic                    neg_q;
  logic                    a_neg_q;
  logic                    shortcut_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic [4:0]              resp_rd_q;

  // Request decode.
  logic                    op1_signed, op2_signed;
  logic                    a_neg, b_neg;
  logic [DATA_WIDTH-1:0]   mag_a, mag_b;
  logic                    div_zero, div_ovf, shortcut;
  logic [DATA_WIDTH-1:0]   special_result;

  // One iteration of each datapath and the sign-corrected final results.
  logic [DATA_WIDTH:0]     mul_sum;
  logic [2*DATA_WIDTH-1:0] mul_next;
  logic [2*DATA_WIDTH-1:0] prod_signed;
  logic [DATA_WIDTH-1:0]   mul_result;
  logic [DATA_WIDTH:0]     rem_shift;
  logic                    div_ge;
  logic [DATA_WIDTH-1:0]   div_diff;
  logic [2*DATA_WIDTH-1:0] div_next;
  logic [DATA_WIDTH-1:0]   quo, rem;
  logic [DATA_WIDTH-1:0]   div_result;

  assign req_ready   = (state == IDLE) && rst_n;
  assign resp_valid  = (state == DONE);
  assign resp_result = result_q;
  assign resp_rd     = resp_rd_q;

  always_comb begin
    op1_signed = !req_op[2] ? (req_op[1:0] != 2'b11) : !req_op[0];
    op2_signed = !req_op[2] ? !req_op[1] : !req_op[0];
    a_neg      = op1_signed && req_operand1[DATA_WIDTH-1];
    b_neg      = op2_signed && req_operand2[DATA_WIDTH-1];
    mag_a      = a_neg ? (32'd0 - req_operand1) : req_operand1;
    mag_b      = b_neg ? (32'd0 - req_operand2) : req_operand2;
    div_zero   = (req_operand2 == 32'd0);
    div_ovf    = !req_op[0] && (req_operand1 == 32'h8000_0000) &&
                 (req_operand2 == 32'hFFFF_FFFF);
    shortcut   = req_op[2] && (div_zero || div_ovf);
    if (div_zero)
      special_result = req_op[1] ? req_operand1 : 32'hFFFF_FFFF;
    else
      special_result = req_op[1] ? 32'd0 : 32'h8000_0000;
  end

  // acc_q holds {high partial product, remaining multiplier} for multiply
  // and {partial remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next    = {mul_sum, acc_q[31:1]};
    prod_signed = neg_q ? (64'd0 - mul_next) : mul_next;
    mul_result  = (op_q == 2'b00) ? prod_signed[31:0] : prod_signed[63:32];

    rem_shift   = {acc_q[63:32], acc_q[31]};
    div_ge      = rem_shift >= {1'b0, opnd_q};
    div_diff    = rem_shift[31:0] - opnd_q;
    div_next    = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                         : {rem_shift[31:0], acc_q[30:0], 1'b0};
    quo         = div_next[31:0];
    rem         = div_next[63:32];
    if (op_q[1])
      div_result = a_neg_q ? (32'd0 - rem) : rem;
    else
      div_result = neg_q ? (32'd0 - quo) : quo;
  end

  // Control FSM and datapath registers. Reset beats flush, flush beats
  // every handshake; request inputs are only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      a_neg_q    <= 1'b0;
      shortcut_q <= 1'b0;
      result_q   <= '0;
      resp_rd_q  <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op[1:0];
            rd_q       <= req_rd;
            neg_q      <= a_neg ^ b_neg;
            a_neg_q    <= a_neg;
            shortcut_q <= shortcut;
            cnt        <= '0;
            if (req_op[2]) begin
              state  <= DIV;
              opnd_q <= mag_b;
              acc_q  <= shortcut ? {32'd0, special_result} : {32'd0, mag_a};
            end else begin
              state  <= MUL;
              opnd_q <= mag_a;
              acc_q  <= {32'd0, mag_b};
            end
          end
        end
        MUL: begin
          acc_q <= mul_next;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result_q  <= mul_result;
            resp_rd_q <= rd_q;
            state     <= DONE;
          end
        end
        DIV: begin
          if (shortcut_q) begin
            result_q  <= acc_q[31:0];
            resp_rd_q <= rd_q;
            state     <= DONE;
          end else begin
            acc_q <= div_next;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              result_q  <= div_result;
              resp_rd_q <= rd_q;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have no module parameters; DATA_WIDTH SHALL be taken from package _riscv_defines (value 32), and all data ports SHALL be DATA_WIDTH bits wide.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 flush  input  1  kill any in-flight or pending operation (pipeline redirect).
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 req_operand1  input  32  rs1 value.
REQ-009 req_operand2  input  32  rs2 value.
REQ-010 req_rd  input  5  destination tag; passed through unchanged.
REQ-011 resp_valid  output  1  result present.
REQ-012 resp_ready  input  1  consumer accepts the result.
REQ-013 resp_result  output  32  RV32M result.
REQ-014 resp_rd  output  5  tag of the completed request.

Function
REQ-015 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-016 req_ready SHALL equal (state==IDLE); a request SHALL be accepted on an edge where req_valid && req_ready && !flush, latching op, operands and rd.
REQ-017 On acceptance, ops 000-011 SHALL go to MUL and ops 100-111 SHALL go to DIV, with the iteration counter set to 0.
REQ-018 MUL SHALL be a radix-2 shift-add over 32-bit magnitudes producing a 64-bit product, one iteration per cycle, for 32 iterations.
REQ-019 DIV SHALL be restoring division over magnitudes, one quotient bit per cycle, for 32 iterations.
REQ-020 After the 32nd iteration edge, the FSM SHALL enter DONE with the final result registered.
REQ-021 resp_valid SHALL therefore be high in the cycle that follows 32 cycles after the accepting edge.
REQ-022 Signedness SHALL be: MUL, MULH and DIV/REM treat both operands as signed; MULHSU treats operand1 as signed and operand2 as unsigned; MULHU, DIVU and REMU treat both as unsigned.
REQ-023 Signed magnitudes SHALL be two's-complement absolute values, and result sign correction SHALL be applied when entering DONE.
REQ-024 Result selection SHALL be: MUL = product[31:0]; MULH, MULHSU, MULHU = product[63:32].
REQ-025 Quotient sign SHALL be the XOR of the operand signs; remainder sign SHALL be the dividend sign.
REQ-026 Divide by zero (operand2==0) SHALL skip iteration and enter DONE on the next edge: DIV/DIVU = 0xFFFFFFFF; REM/REMU = operand1.
REQ-027 Signed overflow (DIV/REM with operand1==0x80000000 and operand2==0xFFFFFFFF) SHALL skip iteration and enter DONE on the next edge: DIV = 0x80000000; REM = 0.
REQ-028 Multiply by zero SHALL NOT shortcut; it SHALL take the full 32 iterations.
REQ-029 In DONE, resp_valid=1 and resp_result/resp_rd SHALL be stable until the handshake completes.
REQ-030 On resp_valid && resp_ready, the FSM SHALL return to IDLE on that edge.
REQ-031 No new request SHALL be accepted on the same edge as a response handshake; req_ready SHALL rise in the following cycle.
REQ-032 flush=1 SHALL force IDLE on the next edge from any state, including DONE with resp_ready=0; the aborted result SHALL never be presented.
REQ-033 flush SHALL override a simultaneous req_valid (no acceptance).
REQ-034 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-035 On a clk edge with rst_n=0, the FSM SHALL enter IDLE and the counter SHALL clear, regardless of the in-flight operation, which SHALL be discarded.
REQ-036 While in reset: req_ready=0, resp_valid=0, resp_result=0, resp_rd=0.
REQ-037 After reset: resp_valid=0, resp_result=0, resp_rd=0, and req_ready=1 starting in the first cycle after rst_n returns high.
REQ-038 Reset SHALL take priority over flush and all handshakes.

Verification
REQ-039 MUL 7 x -3, rd=5, resp_ready=1 -> resp_valid high 32 cycles after accept; result 0xFFFFFFEB; resp_rd=5; req_ready high again the following cycle.
REQ-040 MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-041 DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
REQ-042 DIV 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000. REM of the same -> 0. Each of these responds on the edge after accept.
REQ-043 Hold resp_ready=0 for 10 cycles after DONE -> resp_valid, resp_result and resp_rd stable for all 10 cycles; req_valid pulses during that window are not accepted.
REQ-044 Assert flush at iteration 10, and separately assert rst_n=0 at iteration 20 -> no resp_valid in either case; IDLE next edge (req_ready=1 the cycle after); a following DIVU 100/7 returns 14.
